// File: rtl/branch_pred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// a registered one-cycle prediction path and a saturating mispredict counter.
module branch_pred_btb #(
    parameter int unsigned NENTRIES = 8,
    parameter int unsigned CTR_W    = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             update_valid,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             update_mispredict,
    output logic [CTR_W-1:0] mispred_count
);

    localparam int unsigned IDX_W = $clog2(NENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic [NENTRIES-1:0] valid_q, valid_d;
    tag_t                tag_q    [NENTRIES];
    tag_t                tag_d    [NENTRIES];
    logic [31:0]         target_q [NENTRIES];
    logic [31:0]         target_d [NENTRIES];
    logic [1:0]          ctr_q    [NENTRIES];
    logic [1:0]          ctr_d    [NENTRIES];

    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [31:0]         pred_target_q, pred_target_d;
    logic [CTR_W-1:0]    mispred_count_q, mispred_count_d;

    idx_t lk_idx, up_idx;
    tag_t lk_tag, up_tag;
    logic lk_hit, lk_taken, up_hit;
    logic unused_update_pc_lsbs;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[31:IDX_W+2];

    // Word-aligned PCs: the byte-offset bits of the update PC carry no information.
    assign unused_update_pc_lsbs = ^update_pc[1:0];

    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Prediction reads the table state before this cycle's update lands.
    always_comb begin
        pred_valid_d  = lookup_valid;
        pred_taken_d  = 1'b0;
        pred_target_d = 32'd0;
        if (lookup_valid) begin
            pred_taken_d  = lk_taken;
            pred_target_d = lk_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    ctr_d[up_idx]    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    target_d[up_idx] = update_target;
                end else begin
                    ctr_d[up_idx]    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = update_target;
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    always_comb begin
        mispred_count_d = mispred_count_q;
        if (update_valid && update_mispredict && (mispred_count_q != {CTR_W{1'b1}})) begin
            mispred_count_d = mispred_count_q + CTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_q         <= '0;
            pred_valid_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            pred_target_q   <= 32'd0;
            mispred_count_q <= '0;
            for (int i = 0; i < int'(NENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            pred_valid_q    <= pred_valid_d;
            pred_taken_q    <= pred_taken_d;
            pred_target_q   <= pred_target_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_taken    = pred_taken_q;
    assign pred_target   = pred_target_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_pred_btb.sv
// Directed bench for branch_pred_btb: a behavioural table model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_branch_pred_btb;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;

    logic        pred_valid, pred_taken, pred_valid_s, pred_taken_s;
    logic [31:0] pred_target, pred_target_s;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    branch_pred_btb #(.NENTRIES(N), .CTR_W(16)) dut (
        .clk(clk), .nrst(nrst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .mispred_count(cnt16)
    );

    branch_pred_btb #(.NENTRIES(N), .CTR_W(4)) dut_small (
        .clk(clk), .nrst(nrst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid_s), .pred_taken(pred_taken_s), .pred_target(pred_target_s),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .mispred_count(cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: entries keyed by index, holding the full tag value and an int counter.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int          m_ctr   [N];
    bit [31:0]   m_tgt   [N];
    bit          e_pv, e_pt;
    bit [31:0]   e_tgt;
    int unsigned e_cnt16, e_cnt4;
    bit          armed = 0;

    always @(posedge clk) begin
        int unsigned li, ui;
        bit hit, uhit;
        if (!nrst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
            end
            e_pv = 0; e_pt = 0; e_tgt = 0; e_cnt16 = 0; e_cnt4 = 0;
            armed = 1;
        end else begin
            li    = (lookup_pc / 4) % N;
            hit   = m_valid[li] && (m_tag[li] == (lookup_pc >> (IDX_W + 2)));
            e_pv  = lookup_valid;
            e_pt  = lookup_valid && hit && (m_ctr[li] >= 2);
            e_tgt = !lookup_valid ? 32'd0 : (e_pt ? m_tgt[li] : lookup_pc + 32'd4);
            if (update_valid) begin
                ui   = (update_pc / 4) % N;
                uhit = m_valid[ui] && (m_tag[ui] == (update_pc >> (IDX_W + 2)));
                if (uhit) begin
                    m_ctr[ui] = update_taken ? ((m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1)
                                             : ((m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1);
                    if (update_taken) m_tgt[ui] = update_target;
                end else if (update_taken) begin
                    m_valid[ui] = 1;
                    m_tag[ui]   = update_pc >> (IDX_W + 2);
                    m_tgt[ui]   = update_target;
                    m_ctr[ui]   = 2;
                end
                if (update_mispredict) begin
                    if (e_cnt16 < 65535) e_cnt16++;
                    if (e_cnt4 < 15) e_cnt4++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_pred_valid", {31'd0, pred_valid}, {31'd0, e_pv});
            check("cyc_pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
            check("cyc_pred_target", pred_target, e_tgt);
            check("cyc_cnt16", {16'd0, cnt16}, e_cnt16);
            check("cyc_cnt4", {28'd0, cnt4}, e_cnt4);
            check("cyc_small_target", pred_target_s, e_tgt);
        end
    end

    task automatic tick(input logic rn, input logic lv, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic um);
        @(negedge clk);
        nrst = rn; lookup_valid = lv; lookup_pc = lpc;
        update_valid = uv; update_pc = upc; update_taken = ut;
        update_target = utgt; update_mispredict = um;
        @(posedge clk);
        #1;
    endtask

    task automatic lk(input logic [31:0] pc);
        tick(1, 1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        tick(1, 0, 0, 1, pc, t, tgt, 0);
    endtask

    task automatic expect_pred(input string name, input logic v, input logic t,
                               input logic [31:0] tgt);
        check({name, "_valid"}, {31'd0, pred_valid}, {31'd0, v});
        check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({name, "_target"}, pred_target, tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 0; lookup_valid = 0; lookup_pc = 0; update_valid = 0; update_pc = 0;
        update_taken = 0; update_target = 0; update_mispredict = 0;
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 32'h100, 1, 32'h100, 1, 32'h200, 1);
        expect_pred("reset", 0, 0, 0);
        check("reset_cnt", {16'd0, cnt16}, 0);

        lk(32'h100);
        expect_pred("cold_miss", 1, 0, 32'h104);

        upd(32'h100, 1, 32'h200);
        lk(32'h100);
        expect_pred("alloc", 1, 1, 32'h200);

        upd(32'h100, 0, 0);
        upd(32'h100, 0, 0);
        lk(32'h100);
        expect_pred("sat_low", 1, 0, 32'h104);
        for (int i = 0; i < 3; i++) upd(32'h100, 1, 32'h200);
        upd(32'h100, 0, 0);
        lk(32'h100);
        expect_pred("sat_high", 1, 1, 32'h200);

        upd(32'h120, 1, 32'h300);
        lk(32'h100);
        expect_pred("alias_evict", 1, 0, 32'h104);
        lk(32'h120);
        expect_pred("alias_new", 1, 1, 32'h300);

        tick(1, 1, 32'h144, 1, 32'h144, 1, 32'h400, 0);
        expect_pred("same_cycle", 1, 0, 32'h148);
        lk(32'h144);
        expect_pred("next_cycle", 1, 1, 32'h400);

        for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 32'h800, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 32'h800, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        expect_pred("idle", 0, 0, 0);
        check("mispred_5", {16'd0, cnt16}, 5);
        check("mispred_5_small", {28'd0, cnt4}, 5);
        for (int i = 0; i < 15; i++) tick(1, 0, 0, 1, 32'h800, 0, 0, 1);
        check("mispred_20", {16'd0, cnt16}, 20);
        check("mispred_sat_small", {28'd0, cnt4}, 32'hF);

        lk(32'h144);
        expect_pred("pre_reset", 1, 1, 32'h400);
        tick(0, 1, 32'h144, 1, 32'h144, 1, 32'h500, 1);
        expect_pred("mid_reset", 0, 0, 0);
        check("mid_reset_cnt", {16'd0, cnt16}, 0);
        lk(32'h144);
        expect_pred("post_reset_miss", 1, 0, 32'h148);
        lk(32'h120);
        expect_pred("post_reset_miss2", 1, 0, 32'h124);
        tick(1, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
